// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin arbiter sharing one synchronous FIFO write port
//                among NREQ valid/ready producers. One producer owns the port
//                for at most BURST_LEN accepted beats. Ownership then rotates,
//                or it rotates earlier if the owner drops valid. Writes are
//                combinational from the owner's data to the FIFO.
//                Optional statistics counters are enabled by defining the
//                macro FIFO_WR_ARB_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 32,
    parameter int BURST_LEN = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DW-1:0]        req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_we,
    output logic [DW-1:0]             fifo_wr_data,
    output logic                      grant_valid,
    output logic [$clog2(NREQ)-1:0]   grant_id
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    input  logic                      stat_clr,
    output logic [NREQ*16-1:0]        stat_beats,
    output logic [15:0]               stat_stall
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              c_iw        = $clog2(NREQ);
    localparam int              c_sw        = c_iw + 1;
    localparam int              c_bw        = $clog2(BURST_LEN) + 1;
    localparam logic [c_bw-1:0] c_last_beat = c_bw'(BURST_LEN - 1);
    localparam logic [c_iw-1:0] c_last_id   = c_iw'(NREQ - 1);
    localparam logic [c_sw-1:0] c_nreq_w    = c_sw'(NREQ);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state and next-state values
    // ------------------------------------------------------------------------
    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_iw-1:0] r_grant_id;
    logic [c_iw-1:0] w_grant_id_nxt;
    logic [c_iw-1:0] r_rr_ptr;
    logic [c_iw-1:0] w_rr_ptr_nxt;
    logic [c_bw-1:0] r_beat_cnt;
    logic [c_bw-1:0] w_beat_cnt_nxt;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [NREQ-1:0] w_owner_onehot;
    logic            w_own_valid;
    logic [DW-1:0]   w_own_data;
    logic            w_in_grant;
    logic            w_accept;
    logic            w_rel_full;
    logic            w_rel_drop;
    logic            w_release;
    logic [c_iw-1:0] w_next_ptr;
    logic [c_iw-1:0] w_arb_ptr;
    logic [NREQ-1:0] w_arb_req;
    logic            w_arb_found;
    logic [c_iw-1:0] w_arb_winner;
    logic [c_sw-1:0] w_scan_idx;

    // Select the current owner's valid and data, and its one-hot position.
    always_comb begin
        w_owner_onehot = '0;
        w_own_valid    = 1'b0;
        w_own_data     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (r_grant_id == c_iw'(k)) begin
                w_owner_onehot[k] = 1'b1;
                w_own_valid       = req_valid[k];
                w_own_data        = req_data[k*DW +: DW];
            end
        end
    end

    // Beat acceptance and the two release conditions of an active grant.
    always_comb begin
        w_in_grant = (r_state == S_GRANT);
        w_accept   = w_in_grant && w_own_valid && !fifo_full;
        w_rel_full = w_accept && (r_beat_cnt == c_last_beat);
        w_rel_drop = w_in_grant && !w_own_valid;
        w_release  = w_rel_full || w_rel_drop;
        // Wrap by explicit compare so non-power-of-2 NREQ rotates correctly.
        w_next_ptr = (r_grant_id == c_last_id) ? '0 : r_grant_id + c_iw'(1);
    end

    // Arbitration inputs: IDLE scans from rr_ptr. A releasing grant scans from
    // the slot after the owner, so a full-burst owner ranks last. An owner that
    // dropped valid is masked out explicitly.
    always_comb begin
        w_arb_ptr = w_in_grant ? w_next_ptr : r_rr_ptr;
        w_arb_req = req_valid;
        if (w_rel_drop) begin
            w_arb_req = req_valid & ~w_owner_onehot;
        end
    end

    // Round-robin scan: the lowest offset from w_arb_ptr with a request wins.
    // Offsets are walked high-to-low so the last hit is the closest one.
    always_comb begin
        w_arb_found  = 1'b0;
        w_arb_winner = '0;
        w_scan_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_scan_idx = {1'b0, w_arb_ptr} + c_sw'(k);
            if (w_scan_idx >= c_nreq_w) begin
                w_scan_idx = w_scan_idx - c_nreq_w;
            end
            if (w_arb_req[w_scan_idx[c_iw-1:0]]) begin
                w_arb_found  = 1'b1;
                w_arb_winner = w_scan_idx[c_iw-1:0];
            end
        end
    end

    // Next-state logic for the IDLE/GRANT controller.
    always_comb begin
        w_state_nxt    = r_state;
        w_grant_id_nxt = r_grant_id;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_arb_found) begin
                    w_state_nxt    = S_GRANT;
                    w_grant_id_nxt = w_arb_winner;
                    w_beat_cnt_nxt = '0;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_rr_ptr_nxt   = w_next_ptr;
                    w_beat_cnt_nxt = '0;
                    if (w_arb_found) begin
                        // Hand over in the same cycle; no bubble between owners.
                        w_grant_id_nxt = w_arb_winner;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_accept) begin
                    w_beat_cnt_nxt = r_beat_cnt + c_bw'(1);
                end
                // Full with valid held: nothing changes, grant is kept.
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_grant_id <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_id_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Outputs: gated by rst so a reset cycle never writes or signals a grant.
    always_comb begin
        grant_valid  = 1'b0;
        req_ready    = '0;
        fifo_we      = 1'b0;
        fifo_wr_data = '0;
        if (!rst && w_in_grant) begin
            grant_valid = 1'b1;
            if (!fifo_full) begin
                req_ready = w_owner_onehot;
            end
            if (w_accept) begin
                fifo_we      = 1'b1;
                fifo_wr_data = w_own_data;
            end
        end
    end

    assign grant_id = r_grant_id;

`ifdef FIFO_WR_ARB_STATS_EN
    // ------------------------------------------------------------------------
    // Statistics: 16-bit saturating counters, cleared by rst or stat_clr.
    // ------------------------------------------------------------------------
    logic        w_stall;
    logic [15:0] r_stat_stall;

    assign w_stall = w_in_grant && w_own_valid && fifo_full;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat_beats
        logic        w_inc;
        logic [15:0] r_cnt;

        assign w_inc = fifo_we && (r_grant_id == c_iw'(gi));

        // Count beats accepted from this requester; clear wins over increment.
        always_ff @(posedge clk) begin
            if (rst || stat_clr) begin
                r_cnt <= '0;
            end else if (w_inc && (r_cnt != 16'hFFFF)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end

        assign stat_beats[gi*16 +: 16] = r_cnt;
    end

    // Count cycles where the owner is waiting on a full FIFO.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            r_stat_stall <= '0;
        end else if (w_stall && (r_stat_stall != 16'hFFFF)) begin
            r_stat_stall <= r_stat_stall + 16'd1;
        end
    end

    assign stat_stall = r_stat_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Self-checking bench for fifo_wr_arbiter (directed scenarios
//                plus randomized traffic against a behavioural model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 32;
    localparam int BURST_LEN = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 fifo_full;
    logic                 fifo_we;
    logic [DW-1:0]        fifo_wr_data;
    logic                 grant_valid;
    logic [1:0]           grant_id;
`ifdef FIFO_WR_ARB_STATS_EN
    logic                 stat_clr;
    logic [NREQ*16-1:0]   stat_beats;
    logic [15:0]          stat_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .BURST_LEN (BURST_LEN)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_we      (fifo_we),
        .fifo_wr_data (fifo_wr_data),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_beats   (stat_beats),
        .stat_stall   (stat_stall)
`endif
    );

    // Observed outputs packed as {gv, gid (only meaningful when gv), we, ready, data}.
    function automatic logic [39:0] pack_obs();
        return {grant_valid, (grant_valid ? grant_id : 2'd0), fifo_we, req_ready, fifo_wr_data};
    endfunction

    function automatic logic [39:0] pack_exp(input logic gv, input logic [1:0] gid,
                                             input logic we, input logic [3:0] rdy,
                                             input logic [31:0] d);
        return {gv, (gv ? gid : 2'd0), we, rdy, d};
    endfunction

    // First requester at or after 'start' (cyclically) with its bit set, or -1.
    function automatic int pick(input int start, input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (v[(start + k) % NREQ]) r = (start + k) % NREQ;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        fifo_full = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        step();
        rst = 1'b0;
    endtask

    task automatic set_data(input logic [31:0] base);
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = base + 32'(i);
    endtask

    task automatic test_reset();
        logic [39:0] e;
        rst       = 1'b1;
        req_valid = 4'b1111;
        fifo_full = 1'b0;
        set_data(32'h5555_0000);
        #2;
        e = pack_exp(1'b0, 2'd0, 1'b0, 4'b0000, 32'h0);
        checks++;
        if (pack_obs() !== e) begin
            errors++;
            $display("FAIL reset_cycle0 got %h exp %h", pack_obs(), e);
        end
        step();
        #1;
        checks++;
        if (pack_obs() !== e || grant_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_cycle1 got %h gid %0d exp %h gid 0", pack_obs(), grant_id, e);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (pack_obs() !== e) begin
            errors++;
            $display("FAIL reset_idle got %h exp %h", pack_obs(), e);
        end
        step();
    endtask

    task automatic test_single();
        logic [39:0] e;
        do_reset();
        for (int c = 0; c <= 8; c++) begin
            req_valid = (c <= 6) ? 4'b0001 : 4'b0000;
            req_data  = '0;
            req_data[31:0] = 32'hA0 + 32'((c == 0) ? 0 : c - 1);
            #1;
            if (c == 0 || c == 8) e = pack_exp(1'b0, 2'd0, 1'b0, 4'b0000, 32'h0);
            else if (c == 7)      e = pack_exp(1'b1, 2'd0, 1'b0, 4'b0001, 32'h0);
            else                  e = pack_exp(1'b1, 2'd0, 1'b1, 4'b0001, 32'hA0 + 32'(c - 1));
            checks++;
            if (pack_obs() !== e) begin
                errors++;
                $display("FAIL single c=%0d got %h exp %h", c, pack_obs(), e);
            end
            step();
        end
    endtask

    task automatic test_fairness();
        logic [39:0] e;
        int          g;
        int          pulses;
        do_reset();
        req_valid = 4'b1111;
        set_data(32'hC0DE_0000);
        pulses = 0;
        for (int c = 0; c <= 20; c++) begin
            #1;
            if (c == 0) begin
                e = pack_exp(1'b0, 2'd0, 1'b0, 4'b0000, 32'h0);
            end else begin
                g = ((c - 1) / BURST_LEN) % NREQ;
                e = pack_exp(1'b1, 2'(g), 1'b1, 4'(1 << g), 32'hC0DE_0000 + 32'(g));
            end
            if (fifo_we) pulses++;
            checks++;
            if (pack_obs() !== e) begin
                errors++;
                $display("FAIL fairness c=%0d got %h exp %h", c, pack_obs(), e);
            end
            step();
        end
        checks++;
        if (pulses != 20) begin
            errors++;
            $display("FAIL fairness_pulses got %0d exp 20", pulses);
        end
        req_valid = '0;
        step();
        step();
    endtask

    task automatic test_early_release();
        logic [39:0] e;
        do_reset();
        set_data(32'hE000_0000);
        for (int c = 0; c <= 8; c++) begin
            req_valid = (c <= 2) ? 4'b1010 : 4'b1001;
            #1;
            if (c == 0)      e = pack_exp(1'b0, 2'd0, 1'b0, 4'b0000, 32'h0);
            else if (c <= 2) e = pack_exp(1'b1, 2'd1, 1'b1, 4'b0010, 32'hE000_0001);
            else if (c == 3) e = pack_exp(1'b1, 2'd1, 1'b0, 4'b0010, 32'h0);
            else if (c <= 7) e = pack_exp(1'b1, 2'd3, 1'b1, 4'b1000, 32'hE000_0003);
            else             e = pack_exp(1'b1, 2'd0, 1'b1, 4'b0001, 32'hE000_0000);
            checks++;
            if (pack_obs() !== e) begin
                errors++;
                $display("FAIL early_release c=%0d got %h exp %h", c, pack_obs(), e);
            end
            step();
        end
        req_valid = '0;
        step();
        step();
    endtask

    task automatic test_backpressure();
        logic [39:0] e;
        do_reset();
        set_data(32'hB000_0000);
        for (int c = 0; c <= 10; c++) begin
            req_valid = (c <= 1) ? 4'b0100 : 4'b0101;
            fifo_full = (c >= 2 && c <= 6);
            #1;
            if (c == 0)      e = pack_exp(1'b0, 2'd0, 1'b0, 4'b0000, 32'h0);
            else if (c == 1) e = pack_exp(1'b1, 2'd2, 1'b1, 4'b0100, 32'hB000_0002);
            else if (c <= 6) e = pack_exp(1'b1, 2'd2, 1'b0, 4'b0000, 32'h0);
            else if (c <= 9) e = pack_exp(1'b1, 2'd2, 1'b1, 4'b0100, 32'hB000_0002);
            else             e = pack_exp(1'b1, 2'd0, 1'b1, 4'b0001, 32'hB000_0000);
            checks++;
            if (pack_obs() !== e) begin
                errors++;
                $display("FAIL backpressure c=%0d got %h exp %h", c, pack_obs(), e);
            end
            step();
        end
        fifo_full = 1'b0;
        req_valid = '0;
        step();
        step();
    endtask

    task automatic test_reset_mid();
        logic [39:0] e;
        do_reset();
        set_data(32'hD000_0000);
        for (int c = 0; c <= 9; c++) begin
            rst       = (c == 7);
            req_valid = (c <= 7) ? 4'b0110 : 4'b0111;
            #1;
            if (c == 0 || c == 7 || c == 8) e = pack_exp(1'b0, 2'd0, 1'b0, 4'b0000, 32'h0);
            else if (c <= 4) e = pack_exp(1'b1, 2'd1, 1'b1, 4'b0010, 32'hD000_0001);
            else if (c <= 6) e = pack_exp(1'b1, 2'd2, 1'b1, 4'b0100, 32'hD000_0002);
            else             e = pack_exp(1'b1, 2'd0, 1'b1, 4'b0001, 32'hD000_0000);
            checks++;
            if (pack_obs() !== e) begin
                errors++;
                $display("FAIL reset_mid c=%0d got %h exp %h", c, pack_obs(), e);
            end
            step();
        end
        rst       = 1'b0;
        req_valid = '0;
        step();
        step();
    endtask

    task automatic test_random();
        logic [39:0]     e;
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] cand;
        logic [3:0]      e_rdy;
        logic [31:0]     e_d;
        logic            e_gv;
        logic            e_we;
        logic [1:0]      e_gid;
        logic            own;
        logic            pend [NREQ];
        logic [31:0]     pdata [NREQ];
        int              owner;
        int              beats;
        int              ptr;
        int              dens;
        do_reset();
        owner = -1;
        beats = 0;
        ptr   = 0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i]  = 1'b0;
            pdata[i] = '0;
        end
        for (int n = 0; n < 3000; n++) begin
            dens = (n / 500) % 3;
            // Producers hold data until accepted; idle ones start with some odds.
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 3) < 32'(dens + 1))) begin
                    pend[i]  = 1'b1;
                    pdata[i] = $urandom;
                end
                v[i] = pend[i];
                req_data[i*DW +: DW] = pend[i] ? pdata[i] : $urandom;
            end
            req_valid = v;
            fifo_full = ($urandom_range(0, 3) == 0);

            e_gv  = (owner >= 0);
            e_gid = 2'd0;
            e_we  = 1'b0;
            e_rdy = 4'b0000;
            e_d   = 32'h0;
            if (owner < 0) begin
                owner = pick(ptr, v);
                beats = 0;
            end else begin
                own   = v[owner];
                e_gid = 2'(owner);
                if (!fifo_full) e_rdy[owner] = 1'b1;
                if (own && !fifo_full) begin
                    e_we        = 1'b1;
                    e_d         = pdata[owner];
                    pend[owner] = 1'b0;
                    beats++;
                end
                if (!own || beats == BURST_LEN) begin
                    ptr  = (owner + 1) % NREQ;
                    cand = v;
                    if (!own) cand[owner] = 1'b0;
                    owner = pick(ptr, cand);
                    beats = 0;
                end
            end
            e = pack_exp(e_gv, e_gid, e_we, e_rdy, e_d);
            #1;
            checks++;
            if (pack_obs() !== e) begin
                errors++;
                $display("FAIL random n=%0d got %h exp %h", n, pack_obs(), e);
            end
            step();
        end
        req_valid = '0;
        fifo_full = 1'b0;
        step();
        step();
    endtask

`ifdef FIFO_WR_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        #1;
        checks++;
        if (stat_beats !== '0 || stat_stall !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset got beats %h stall %0d exp 0", stat_beats, stat_stall);
        end
        req_valid = 4'b1111;
        set_data(32'h5A00_0000);
        for (int c = 0; c <= 32; c++) step();
        req_valid = '0;
        step();
        step();
        #1;
        for (int i = 0; i < NREQ; i++) begin
            checks++;
            if (stat_beats[i*16 +: 16] !== 16'd8) begin
                errors++;
                $display("FAIL stats_beats id=%0d got %0d exp 8", i, stat_beats[i*16 +: 16]);
            end
        end
        req_valid = 4'b0001;
        step();
        fifo_full = 1'b1;
        step();
        step();
        step();
        fifo_full = 1'b0;
        req_valid = '0;
        step();
        step();
        #1;
        checks++;
        if (stat_stall !== 16'd3 || stat_beats[15:0] !== 16'd8) begin
            errors++;
            $display("FAIL stats_stall got stall %0d beats0 %0d exp 3 and 8", stat_stall, stat_beats[15:0]);
        end
        req_valid = 4'b0001;
        step();
        stat_clr = 1'b1;
        step();
        stat_clr  = 1'b0;
        req_valid = '0;
        #1;
        checks++;
        if (stat_beats !== '0 || stat_stall !== 16'd0) begin
            errors++;
            $display("FAIL stats_clear got beats %h stall %0d exp 0", stat_beats, stat_stall);
        end
        step();
        step();
    endtask
`endif

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        test_reset();
        test_single();
        test_fairness();
        test_early_release();
        test_backpressure();
        test_reset_mid();
        test_random();
`ifdef FIFO_WR_ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
